regfile_access_unit: RTL and testbench

//  Initiator side of the register-file ports: drives MemoryInterface write and two read ports.

---
 rtl/regfile_access_unit_pkg.sv | 11 +
 rtl/regfile_access_unit_if.sv | 13 +
 rtl/regfile_access_unit_wb_queue.sv | 71 +++++++
 rtl/regfile_access_unit.sv | 87 ++++++++
 tb/tb_regfile_access_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_access_unit_pkg.sv
// Shared register-file geometry and the writeback queue entry type.
package regfile_access_unit_pkg;
    localparam int REGISTER_DEPTH = 32;
    localparam int REGISTER_WIDTH = 32;
    localparam int REG_ADDR_W     = $clog2(REGISTER_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_W-1:0]     addr;
        logic [REGISTER_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_access_unit_if.sv
// MemoryInterface: one register-file port; write_out/read_out face the register file.
interface MemoryInterface;
    import regfile_access_unit_pkg::*;
    logic                      enable;
    logic [REG_ADDR_W-1:0]     address;
    logic [REGISTER_WIDTH-1:0] write_data;
    logic [REGISTER_WIDTH-1:0] read_data;

    modport write_out(output enable, address, write_data);
    modport write_in (input  enable, address, write_data);
    modport read_out (output address, input read_data);
    modport read_in  (input  address, output read_data);
endinterface

// File: rtl/regfile_access_unit_wb_queue.sv
// regfile_wb_queue: circular writeback buffer with head output and a
// youngest-match lookup for two source addresses.
module regfile_wb_queue
    import regfile_access_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic                      full,
    output logic                      empty,
    input  logic [REG_ADDR_W-1:0]     addr_a,
    input  logic [REG_ADDR_W-1:0]     addr_b,
    output logic                      hit_a,
    output logic                      hit_b,
    output logic [REGISTER_WIDTH-1:0] data_a,
    output logic [REGISTER_WIDTH-1:0] data_b
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    wb_entry_t     scan;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // Scan oldest to youngest so the last match seen is the newest value.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        data_a = '0;
        data_b = '0;
        scan   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan = mem[rd_ptr + PW'(i)];
            if ((PW+1)'(i) < count) begin
                if (scan.addr == addr_a) begin
                    hit_a  = 1'b1;
                    data_a = scan.data;
                end
                if (scan.addr == addr_b) begin
                    hit_b  = 1'b1;
                    data_b = scan.data;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_access_unit.sv
// regfile_access_unit: queued writeback drain plus registered operand fetch.
// Define REGFILE_BYPASS_EN to forward queued data; otherwise matching reads stall.
module regfile_access_unit
    import regfile_access_unit_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  logic [REG_ADDR_W-1:0]     wb_addr,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    input  logic                      rd_req_valid,
    output logic                      rd_req_ready,
    input  logic [REG_ADDR_W-1:0]     rs1_addr,
    input  logic [REG_ADDR_W-1:0]     rs2_addr,
    output logic                      rd_rsp_valid,
    input  logic                      rd_rsp_ready,
    output logic [REGISTER_WIDTH-1:0] rs1_data,
    output logic [REGISTER_WIDTH-1:0] rs2_data,
    MemoryInterface.write_out         registerport_write,
    MemoryInterface.read_out          registerport_read_1,
    MemoryInterface.read_out          registerport_read_2
);
    wb_entry_t                 head;
    logic                      full, empty, hit1, hit2, wr_en, wb_push, rsp_free;
    logic [REGISTER_WIDTH-1:0] fwd1, fwd2, op1, op2;

    assign wb_ready = !full;
    assign wb_push  = wb_valid && !full && (wb_addr != '0);

    regfile_wb_queue #(.DEPTH(WB_DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wb_push),
        .push_entry ('{addr: wb_addr, data: wb_data}),
        .pop        (!empty),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .addr_a     (rs1_addr),
        .addr_b     (rs2_addr),
        .hit_a      (hit1),
        .hit_b      (hit2),
        .data_a     (fwd1),
        .data_b     (fwd2)
    );

    // Reset suppresses the write so pending entries never land.
    assign wr_en                         = rst_n && !empty;
    assign registerport_write.enable     = wr_en;
    assign registerport_write.address    = wr_en ? head.addr : '0;
    assign registerport_write.write_data = wr_en ? head.data : '0;
    assign registerport_read_1.address   = rs1_addr;
    assign registerport_read_2.address   = rs2_addr;

    assign rsp_free = !rd_rsp_valid || rd_rsp_ready;

`ifdef REGFILE_BYPASS_EN
    assign rd_req_ready = rsp_free;
    assign op1 = (rs1_addr == '0) ? '0 : hit1 ? fwd1 : registerport_read_1.read_data;
    assign op2 = (rs2_addr == '0) ? '0 : hit2 ? fwd2 : registerport_read_2.read_data;
`else
    logic stall;
    logic unused_fwd;
    assign unused_fwd   = ^{fwd1, fwd2};
    assign stall        = (hit1 && rs1_addr != '0) || (hit2 && rs2_addr != '0);
    assign rd_req_ready = rsp_free && !stall;
    assign op1 = (rs1_addr == '0) ? '0 : registerport_read_1.read_data;
    assign op2 = (rs2_addr == '0) ? '0 : registerport_read_2.read_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_rsp_valid <= 1'b0;
            rs1_data     <= '0;
            rs2_data     <= '0;
        end else if (rd_req_valid && rd_req_ready) begin
            rd_rsp_valid <= 1'b1;
            rs1_data     <= op1;
            rs2_data     <= op2;
        end else if (rd_rsp_ready) begin
            rd_rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_access_unit.sv
// Randomized bench for regfile_access_unit against a queue/array reference model.
module tb_regfile_access_unit;
    import regfile_access_unit_pkg::*;

    localparam int WB_DEPTH = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      wb_valid, wb_ready;
    logic [REG_ADDR_W-1:0]     wb_addr;
    logic [REGISTER_WIDTH-1:0] wb_data;
    logic                      rd_req_valid, rd_req_ready;
    logic [REG_ADDR_W-1:0]     rs1_addr, rs2_addr;
    logic                      rd_rsp_valid, rd_rsp_ready;
    logic [REGISTER_WIDTH-1:0] rs1_data, rs2_data;

    MemoryInterface wr_if();
    MemoryInterface rd1_if();
    MemoryInterface rd2_if();

    regfile_access_unit #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wb_valid            (wb_valid),
        .wb_ready            (wb_ready),
        .wb_addr             (wb_addr),
        .wb_data             (wb_data),
        .rd_req_valid        (rd_req_valid),
        .rd_req_ready        (rd_req_ready),
        .rs1_addr            (rs1_addr),
        .rs2_addr            (rs2_addr),
        .rd_rsp_valid        (rd_rsp_valid),
        .rd_rsp_ready        (rd_rsp_ready),
        .rs1_data            (rs1_data),
        .rs2_data            (rs2_data),
        .registerport_write  (wr_if),
        .registerport_read_1 (rd1_if),
        .registerport_read_2 (rd2_if)
    );

    always #5 clk = ~clk;

    // Register file environment driven by the DUT's ports.
    logic [REGISTER_WIDTH-1:0] rf [REGISTER_DEPTH];
    always @(posedge clk) if (wr_if.enable) rf[wr_if.address] <= wr_if.write_data;
    assign rd1_if.read_data = rf[rd1_if.address];
    assign rd2_if.read_data = rf[rd2_if.address];
    assign wr_if.read_data  = '0;

    // Reference model state.
    wb_entry_t                 mq[$];
    logic [REGISTER_WIDTH-1:0] mrf [REGISTER_DEPTH];
    bit                        m_rsp_valid;
    logic [REGISTER_WIDTH-1:0] m_rs1, m_rs2;
    bit                        last_wb_acc, last_rd_acc;
    int                        n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [REG_ADDR_W-1:0] a, output bit hit,
                                   output logic [REGISTER_WIDTH-1:0] v);
        hit = 1'b0;
        v   = '0;
        foreach (mq[i]) if (mq[i].addr == a) begin hit = 1'b1; v = mq[i].data; end
    endfunction

    function automatic logic [REGISTER_WIDTH-1:0] operand(input logic [REG_ADDR_W-1:0] a,
                                                          input bit hit, input logic [REGISTER_WIDTH-1:0] v);
        if (a == '0) return '0;
        if (BYPASS && hit) return v;
        return mrf[a];
    endfunction

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic step();
        bit hit1, hit2, exp_wbr, exp_rdy;
        logic [REGISTER_WIDTH-1:0] v1, v2, o1, o2;
        @(negedge clk);
        exp_wbr = (mq.size() < WB_DEPTH);
        chk("wb_ready", wb_ready, exp_wbr);
        chk("wr_en", wr_if.enable, rst_n && mq.size() != 0);
        chk("wr_addr", wr_if.address, (rst_n && mq.size() != 0) ? mq[0].addr : '0);
        chk("wr_data", wr_if.write_data, (rst_n && mq.size() != 0) ? mq[0].data : '0);
        chk("rd1_addr", rd1_if.address, rs1_addr);
        chk("rd2_addr", rd2_if.address, rs2_addr);
        chk("rsp_valid", rd_rsp_valid, m_rsp_valid);
        chk("rs1_data", rs1_data, m_rs1);
        chk("rs2_data", rs2_data, m_rs2);
        lookup(rs1_addr, hit1, v1);
        lookup(rs2_addr, hit2, v2);
        exp_rdy = (!m_rsp_valid || rd_rsp_ready) &&
                  (BYPASS || !((rs1_addr != 0 && hit1) || (rs2_addr != 0 && hit2)));
        chk("rd_req_ready", rd_req_ready, exp_rdy);
        o1 = operand(rs1_addr, hit1, v1);
        o2 = operand(rs2_addr, hit2, v2);
        @(posedge clk);
        last_wb_acc = 1'b0;
        last_rd_acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            m_rsp_valid = 1'b0;
            m_rs1 = '0;
            m_rs2 = '0;
        end else begin
            if (rd_req_valid && exp_rdy) begin
                last_rd_acc = 1'b1;
                m_rsp_valid = 1'b1;
                m_rs1 = o1;
                m_rs2 = o2;
            end else if (rd_rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
            if (mq.size() != 0) begin
                mrf[mq[0].addr] = mq[0].data;
                void'(mq.pop_front());
            end
            if (wb_valid && exp_wbr) begin
                last_wb_acc = 1'b1;
                if (wb_addr != '0) mq.push_back('{addr: wb_addr, data: wb_data});
            end
        end
        #1;
    endtask

    task automatic wb_push(input logic [REG_ADDR_W-1:0] a, input logic [31:0] d);
        int n = 0;
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        do begin step(); n++; end while (!last_wb_acc && n < 20);
        chk("wb_acc_timeout", last_wb_acc, 1'b1);
        wb_valid = 1'b0;
    endtask

    task automatic rd_issue(input logic [REG_ADDR_W-1:0] a1, input logic [REG_ADDR_W-1:0] a2);
        int n = 0;
        rd_req_valid = 1'b1; rs1_addr = a1; rs2_addr = a2;
        do begin step(); n++; end while (!last_rd_acc && n < 20);
        chk("rd_acc_timeout", last_rd_acc, 1'b1);
        rd_req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        rd_req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_rsp_ready = 1'b1;
        m_rsp_valid = 1'b0; m_rs1 = '0; m_rs2 = '0;
        @(posedge clk); #1;
        // Reset held with a pending writeback request.
        repeat (2) step();
        chk("rst_wb_ready", wb_ready, 1'b1);
        chk("rst_wr_en", wr_if.enable, 1'b0);
        rst_n = 1'b1; wb_valid = 1'b0;

        // Give every register a known value.
        for (int r = 1; r < REGISTER_DEPTH; r++) wb_push(REG_ADDR_W'(r), $urandom);

        // Fill: back-to-back writebacks x1..x5.
        for (int r = 1; r <= 5; r++) begin
            wb_valid = 1'b1; wb_addr = REG_ADDR_W'(r); wb_data = 32'h11 * r;
            step();
        end
        wb_valid = 1'b0;
        repeat (3) step();
        chk("fill_x5", rf[5], 32'h55);
        chk("fill_x1", rf[1], 32'h11);

        // Forward or stall on x3.
        wb_push(5'd3, 32'hA);
        wb_push(5'd3, 32'hB);
        rd_issue(5'd3, 5'd0);
        chk("x3_rs1", rs1_data, 32'hB);
        chk("x3_rsp_valid", rd_rsp_valid, 1'b1);
        step();

        // x0 writes are dropped and reads of x0 are zero.
        wb_push(5'd0, 32'hFFFF);
        chk("x0_wr_en", wr_if.enable, 1'b0);
        rd_issue(5'd0, 5'd0);
        chk("x0_rs1", rs1_data, 32'h0);
        chk("x0_rs2", rs2_data, 32'h0);
        step();

        // Backpressure on the response.
        rd_issue(5'd1, 5'd2);
        rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; rs1_addr = 5'd4; rs2_addr = 5'd5;
        repeat (3) step();
        chk("bp_hold_rs1", rs1_data, 32'h11);
        rd_rsp_ready = 1'b1;
        step();
        chk("bp_release_acc", last_rd_acc, 1'b1);
        chk("bp_new_rs1", rs1_data, 32'h44);
        rd_req_valid = 1'b0;
        step();

        // Reset with writes in flight.
        for (int r = 6; r <= 8; r++) begin
            wb_valid = 1'b1; wb_addr = REG_ADDR_W'(r); wb_data = 32'hC0 + r;
            step();
        end
        wb_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_wr_en", wr_if.enable, 1'b0);
        repeat (2) step();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            wb_valid     = $urandom_range(0, 1);
            wb_addr      = REG_ADDR_W'($urandom_range(0, 7));
            wb_data      = $urandom;
            rd_req_valid = $urandom_range(0, 1);
            rs1_addr     = REG_ADDR_W'($urandom_range(0, 7));
            rs2_addr     = REG_ADDR_W'($urandom_range(0, 7));
            rd_rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
